cp0_unit: RTL and testbench

CP0_UNIT -- requirements
Module: cp0_unit

---
 rtl/cp0_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_cp0_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - coprocessor-0 system registers, timer, TLB random and exception state
module cp0_unit #(
    parameter int          INDEX_WIDTH = 4,
    parameter int          COUNT_DIV   = 2,
    parameter int          HW_INT      = 6,
    parameter logic [31:0] PRID        = 32'h0001_8000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [HW_INT-1:0]      ext_int,
    input  logic                   req_valid,
    input  logic [2:0]             req_op,
    input  logic [4:0]             req_addr,
    input  logic [2:0]             req_sel,
    input  logic [31:0]            req_wdata,
    input  logic [4:0]             exc_code,
    input  logic                   exc_bd,
    input  logic [31:0]            exc_epc,
    input  logic                   exc_badva_we,
    input  logic [31:0]            exc_badva,
    output logic                   rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic [31:0]            epc,
    output logic [31:0]            status,
    output logic [31:0]            cause,
    output logic [INDEX_WIDTH-1:0] random,
    output logic [INDEX_WIDTH-1:0] index,
    output logic [31:0]            entryhi,
    output logic                   int_req
);

    localparam logic [2:0] OP_MTC0 = 3'd1;
    localparam logic [2:0] OP_MFC0 = 3'd2;
    localparam logic [2:0] OP_EXC  = 3'd3;
    localparam logic [2:0] OP_ERET = 3'd4;

    localparam logic [7:0] R_INDEX   = {5'd0,  3'd0};
    localparam logic [7:0] R_RANDOM  = {5'd1,  3'd0};
    localparam logic [7:0] R_WIRED   = {5'd6,  3'd0};
    localparam logic [7:0] R_BADVA   = {5'd8,  3'd0};
    localparam logic [7:0] R_COUNT   = {5'd9,  3'd0};
    localparam logic [7:0] R_ENTRYHI = {5'd10, 3'd0};
    localparam logic [7:0] R_COMPARE = {5'd11, 3'd0};
    localparam logic [7:0] R_STATUS  = {5'd12, 3'd0};
    localparam logic [7:0] R_CAUSE   = {5'd13, 3'd0};
    localparam logic [7:0] R_EPC     = {5'd14, 3'd0};
    localparam logic [7:0] R_PRID    = {5'd15, 3'd0};
    localparam logic [7:0] R_CONFIG  = {5'd16, 3'd0};

    localparam logic [31:0] ENTRYHI_WMASK = 32'hFFFF_E0FF;
    localparam logic [31:0] STATUS_WMASK  = 32'h0000_FF03;
    localparam logic [31:0] STATUS_RESET  = 32'h0040_0000;
    localparam logic [31:0] CONFIG_VAL    = 32'h8000_0003;

    localparam logic [INDEX_WIDTH-1:0] RAND_MAX = '1;
    localparam logic [INDEX_WIDTH-1:0] IDX_ONE  = 1;
    localparam logic [INDEX_WIDTH:0]   IDX_ONE_W = 1;
    localparam logic [4:0]             PRESC_LAST = 5'(COUNT_DIV - 1);

    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic [INDEX_WIDTH-1:0] random_q, random_d;
    logic [INDEX_WIDTH-1:0] wired_q, wired_d;
    logic [31:0]            badva_q, badva_d;
    logic [31:0]            count_q, count_d;
    logic [4:0]             presc_q, presc_d;
    logic                   tick_seen_q, tick_seen_d;
    logic [31:0]            entryhi_q, entryhi_d;
    logic [31:0]            compare_q, compare_d;
    logic [31:0]            status_q, status_d;
    logic                   bd_q, bd_d;
    logic                   ti_q, ti_d;
    logic [1:0]             ip_sw_q, ip_sw_d;
    logic [HW_INT-1:0]      ip_hw_q, ip_hw_d;
    logic [4:0]             exc_code_q, exc_code_d;
    logic [31:0]            epc_q, epc_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [31:0]            rsp_rdata_q, rsp_rdata_d;

    logic        is_mtc0, is_mfc0, is_exc, is_eret, tick;
    logic [5:0]  ip_ext;
    logic [31:0] cause_w;
    logic [31:0] rd_data;

    assign is_mtc0 = req_valid && (req_op == OP_MTC0);
    assign is_mfc0 = req_valid && (req_op == OP_MFC0);
    assign is_exc  = req_valid && (req_op == OP_EXC);
    assign is_eret = req_valid && (req_op == OP_ERET);
    assign tick    = (presc_q == PRESC_LAST);

    // Assemble Cause; the top hardware IP line is shared with the timer interrupt
    always_comb begin
        ip_ext               = '0;
        ip_ext[HW_INT-1:0]   = ip_hw_q;
        ip_ext[5]            = ip_ext[5] | ti_q;
        cause_w = {bd_q, ti_q, 14'd0, ip_ext, ip_sw_q, 1'b0, exc_code_q, 2'b00};
    end

    // MFC0 read mux over the current (pre-update) register values
    always_comb begin
        rd_data = 32'd0;
        case ({req_addr, req_sel})
            R_INDEX:   rd_data = 32'(index_q);
            R_RANDOM:  rd_data = 32'(random_q);
            R_WIRED:   rd_data = 32'(wired_q);
            R_BADVA:   rd_data = badva_q;
            R_COUNT:   rd_data = count_q;
            R_ENTRYHI: rd_data = entryhi_q;
            R_COMPARE: rd_data = compare_q;
            R_STATUS:  rd_data = status_q;
            R_CAUSE:   rd_data = cause_w;
            R_EPC:     rd_data = epc_q;
            R_PRID:    rd_data = PRID;
            R_CONFIG:  rd_data = CONFIG_VAL;
            default:   rd_data = 32'd0;
        endcase
    end

    // Next-state: free-running timer and Random first, then the accepted request overrides
    always_comb begin
        index_d     = index_q;
        wired_d     = wired_q;
        badva_d     = badva_q;
        entryhi_d   = entryhi_q;
        compare_d   = compare_q;
        status_d    = status_q;
        bd_d        = bd_q;
        ip_sw_d     = ip_sw_q;
        exc_code_d  = exc_code_q;
        epc_d       = epc_q;
        ip_hw_d     = ext_int;
        presc_d     = tick ? 5'd0 : presc_q + 5'd1;
        count_d     = tick ? count_q + 32'd1 : count_q;
        tick_seen_d = tick;
        // Random wraps before it would step onto or below Wired
        random_d    = ({1'b0, random_q} <= ({1'b0, wired_q} + IDX_ONE_W)) ? RAND_MAX
                                                                          : random_q - IDX_ONE;
        // Timer fires once Count has just ticked onto Compare
        ti_d        = ti_q | (tick_seen_q && (count_q == compare_q));
        rsp_valid_d = is_mfc0;
        rsp_rdata_d = is_mfc0 ? rd_data : 32'd0;

        if (is_mtc0) begin
            case ({req_addr, req_sel})
                R_INDEX:   index_d = req_wdata[INDEX_WIDTH-1:0];
                R_WIRED: begin
                    wired_d  = req_wdata[INDEX_WIDTH-1:0];
                    random_d = RAND_MAX;
                end
                R_COUNT: begin
                    count_d     = req_wdata;
                    presc_d     = 5'd0;
                    tick_seen_d = 1'b0;
                end
                R_ENTRYHI: entryhi_d = (entryhi_q & ~ENTRYHI_WMASK) | (req_wdata & ENTRYHI_WMASK);
                R_COMPARE: begin
                    compare_d = req_wdata;
                    ti_d      = 1'b0;
                end
                R_STATUS:  status_d = (status_q & ~STATUS_WMASK) | (req_wdata & STATUS_WMASK);
                R_CAUSE:   ip_sw_d = req_wdata[9:8];
                R_EPC:     epc_d = req_wdata;
                default:   ;
            endcase
        end

        if (is_exc) begin
            exc_code_d  = exc_code;
            status_d[1] = 1'b1;
            // A nested exception keeps the original return point
            if (!status_q[1]) begin
                epc_d = exc_epc;
                bd_d  = exc_bd;
            end
            if (exc_badva_we) begin
                badva_d          = exc_badva;
                entryhi_d[31:13] = exc_badva[31:13];
            end
        end

        if (is_eret) begin
            status_d[1] = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            index_q     <= '0;
            random_q    <= RAND_MAX;
            wired_q     <= '0;
            badva_q     <= 32'd0;
            count_q     <= 32'd0;
            presc_q     <= 5'd0;
            tick_seen_q <= 1'b0;
            entryhi_q   <= 32'd0;
            compare_q   <= 32'd0;
            status_q    <= STATUS_RESET;
            bd_q        <= 1'b0;
            ti_q        <= 1'b0;
            ip_sw_q     <= 2'd0;
            ip_hw_q     <= '0;
            exc_code_q  <= 5'd0;
            epc_q       <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            index_q     <= index_d;
            random_q    <= random_d;
            wired_q     <= wired_d;
            badva_q     <= badva_d;
            count_q     <= count_d;
            presc_q     <= presc_d;
            tick_seen_q <= tick_seen_d;
            entryhi_q   <= entryhi_d;
            compare_q   <= compare_d;
            status_q    <= status_d;
            bd_q        <= bd_d;
            ti_q        <= ti_d;
            ip_sw_q     <= ip_sw_d;
            ip_hw_q     <= ip_hw_d;
            exc_code_q  <= exc_code_d;
            epc_q       <= epc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign epc       = epc_q;
    assign status    = status_q;
    assign cause     = cause_w;
    assign random    = random_q;
    assign index     = index_q;
    assign entryhi   = entryhi_q;
    assign int_req   = status_q[0] & ~status_q[1] & ~status_q[2] & (|(cause_w[15:8] & status_q[15:8]));

endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - self-checking bench for cp0_unit
module tb_cp0_unit;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  ext_int;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [4:0]  req_addr;
    logic [2:0]  req_sel;
    logic [31:0] req_wdata;
    logic [4:0]  exc_code;
    logic        exc_bd;
    logic [31:0] exc_epc;
    logic        exc_badva_we;
    logic [31:0] exc_badva;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [31:0] epc, status, cause, entryhi;
    logic [3:0]  random, index;
    logic        int_req;

    always #5 clk = ~clk;

    cp0_unit dut (
        .clk(clk), .rst(rst), .ext_int(ext_int),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_sel(req_sel),
        .req_wdata(req_wdata), .exc_code(exc_code), .exc_bd(exc_bd), .exc_epc(exc_epc),
        .exc_badva_we(exc_badva_we), .exc_badva(exc_badva),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .epc(epc), .status(status),
        .cause(cause), .random(random), .index(index), .entryhi(entryhi), .int_req(int_req)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural state, with Count and Random derived from elapsed cycles
    logic [3:0]  m_index, m_wired;
    logic [31:0] m_badva, m_entryhi, m_compare, m_status, m_epc, cnt_base;
    logic [1:0]  m_ipsw;
    logic        m_bd, m_ti;
    logic [4:0]  m_code;
    logic [5:0]  m_exti;
    int          cnt_e, rnd_e;
    logic        exp_rv;
    logic [31:0] exp_rd;
    logic [5:0]  ext_val = 6'd0;

    function automatic logic [31:0] mdl_count();
        return cnt_base + 32'(cnt_e / D);
    endfunction

    function automatic logic [3:0] mdl_random();
        int n;
        n = 15 - int'(m_wired);
        if (n <= 0) return 4'hF;
        return 4'(15 - (rnd_e % n));
    endfunction

    function automatic logic [31:0] mdl_cause();
        logic [5:0] ip;
        ip    = m_exti;
        ip[5] = ip[5] | m_ti;
        return {m_bd, m_ti, 14'd0, ip, m_ipsw, 1'b0, m_code, 2'b00};
    endfunction

    function automatic logic mdl_int();
        logic [31:0] c;
        c = mdl_cause();
        return m_status[0] & ~m_status[1] & ~m_status[2] & (|(c[15:8] & m_status[15:8]));
    endfunction

    function automatic logic [31:0] mdl_read(input logic [4:0] a, input logic [2:0] s);
        if (s != 3'd0) return 32'd0;
        case (a)
            5'd0:  return 32'(m_index);
            5'd1:  return 32'(mdl_random());
            5'd6:  return 32'(m_wired);
            5'd8:  return m_badva;
            5'd9:  return mdl_count();
            5'd10: return m_entryhi;
            5'd11: return m_compare;
            5'd12: return m_status;
            5'd13: return mdl_cause();
            5'd14: return m_epc;
            5'd15: return 32'h0001_8000;
            5'd16: return 32'h8000_0003;
            default: return 32'd0;
        endcase
    endfunction

    task automatic mdl_reset();
        m_index = 0; m_wired = 0; m_badva = 0; m_entryhi = 0; m_compare = 0;
        m_status = 32'h0040_0000; m_epc = 0; cnt_base = 0; m_ipsw = 0; m_bd = 0;
        m_ti = 0; m_code = 0; m_exti = 0; cnt_e = 0; rnd_e = 0; exp_rv = 0; exp_rd = 0;
    endtask

    task automatic mdl_step(input logic [2:0] op, input logic [4:0] a, input logic [2:0] s,
                            input logic [31:0] wd, input logic [4:0] ec, input logic bd,
                            input logic [31:0] ep, input logic bwe, input logic [31:0] bva);
        logic ti_n;
        exp_rv = (op == 3'd2);
        exp_rd = mdl_read(a, s);
        ti_n   = m_ti;
        if (cnt_e > 0 && (cnt_e % D) == 0 && mdl_count() == m_compare) ti_n = 1'b1;
        cnt_e++;
        rnd_e++;
        m_exti = ext_val;
        if (op == 3'd1 && s == 3'd0) begin
            case (a)
                5'd0:  m_index = wd[3:0];
                5'd6:  begin m_wired = wd[3:0]; rnd_e = 0; end
                5'd9:  begin cnt_base = wd; cnt_e = 0; end
                5'd10: m_entryhi = (m_entryhi & ~32'hFFFF_E0FF) | (wd & 32'hFFFF_E0FF);
                5'd11: begin m_compare = wd; ti_n = 1'b0; end
                5'd12: m_status = (m_status & ~32'h0000_FF03) | (wd & 32'h0000_FF03);
                5'd13: m_ipsw = wd[9:8];
                5'd14: m_epc = wd;
                default: ;
            endcase
        end else if (op == 3'd3) begin
            m_code = ec;
            if (!m_status[1]) begin m_epc = ep; m_bd = bd; end
            m_status[1] = 1'b1;
            if (bwe) begin m_badva = bva; m_entryhi[31:13] = bva[31:13]; end
        end else if (op == 3'd4) begin
            m_status[1] = 1'b0;
        end
        m_ti = ti_n;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic [2:0] op, input logic [4:0] a,
                       input logic [2:0] s, input logic [31:0] wd, input logic [4:0] ec,
                       input logic bd, input logic [31:0] ep, input logic bwe,
                       input logic [31:0] bva);
        rst = r; req_valid = (op != 3'd0); req_op = op; req_addr = a; req_sel = s;
        req_wdata = wd; exc_code = ec; exc_bd = bd; exc_epc = ep; exc_badva_we = bwe;
        exc_badva = bva; ext_int = ext_val;
        if (r) mdl_reset();
        else   mdl_step(op, a, s, wd, ec, bd, ep, bwe, bva);
        @(posedge clk);
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv) chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("epc", epc, m_epc);
        chk("status", status, m_status);
        chk("cause", cause, mdl_cause());
        chk("random", 32'(random), 32'(mdl_random()));
        chk("index", 32'(index), 32'(m_index));
        chk("entryhi", entryhi, m_entryhi);
        chk("int_req", 32'(int_req), 32'(mdl_int()));
    endtask

    task automatic t_none();                  cyc(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic t_eret();                  cyc(0, 3'd4, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic t_mfc0(input logic [4:0] a, input logic [2:0] s);
        cyc(0, 3'd2, a, s, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic t_mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] wd);
        cyc(0, 3'd1, a, s, wd, 0, 0, 0, 0, 0);
    endtask
    task automatic t_exc(input logic [4:0] ec, input logic bd, input logic [31:0] ep,
                         input logic bwe, input logic [31:0] bva);
        cyc(0, 3'd3, 0, 0, 0, ec, bd, ep, bwe, bva);
    endtask
    task automatic t_reset(input int n);
        for (int i = 0; i < n; i++) cyc(1, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [4:0] pick_addr(input int k);
        case (k)
            0: return 5'd0;   1: return 5'd1;   2: return 5'd6;   3: return 5'd8;
            4: return 5'd9;   5: return 5'd10;  6: return 5'd11;  7: return 5'd12;
            8: return 5'd13;  9: return 5'd14;  10: return 5'd15; 11: return 5'd16;
            default: return 5'd2;
        endcase
    endfunction

    typedef struct {
        logic [4:0]  a;
        logic [2:0]  s;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [4:0]  a;
        logic [31:0] wd;
        int          k_hit;
        logic        found;
        int          r;

        tbl[0]  = '{5'd0,  3'd0, 32'hFFFF_FFFF, 32'h0000_000F};
        tbl[1]  = '{5'd6,  3'd0, 32'h0000_0002, 32'h0000_0002};
        tbl[2]  = '{5'd10, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_E0FF};
        tbl[3]  = '{5'd11, 3'd0, 32'h1234_5678, 32'h1234_5678};
        tbl[4]  = '{5'd12, 3'd0, 32'hFFFF_FFFF, 32'h0040_FF03};
        tbl[5]  = '{5'd12, 3'd0, 32'h0000_0000, 32'h0040_0000};
        tbl[6]  = '{5'd13, 3'd0, 32'hFFFF_FFFF, 32'h0000_0300};
        tbl[7]  = '{5'd14, 3'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tbl[8]  = '{5'd15, 3'd0, 32'h0000_0000, 32'h0001_8000};
        tbl[9]  = '{5'd16, 3'd0, 32'h0000_0000, 32'h8000_0003};
        tbl[10] = '{5'd8,  3'd0, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[11] = '{5'd9,  3'd0, 32'h0000_1000, 32'h0000_1000};
        tbl[12] = '{5'd2,  3'd0, 32'h0000_0055, 32'h0000_0000};
        tbl[13] = '{5'd12, 3'd1, 32'hFFFF_FFFF, 32'h0000_0000};

        // Reset state and first reads
        t_reset(3);
        chk("rst_status", status, 32'h0040_0000);
        chk("rst_cause", cause, 32'd0);
        chk("rst_random", 32'(random), 32'd15);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_int_req", 32'(int_req), 32'd0);
        t_mfc0(5'd1, 3'd0);
        chk("read_random_after_rst", rsp_rdata, 32'd15);
        t_mfc0(5'd12, 3'd0);
        chk("read_status_after_rst", rsp_rdata, 32'h0040_0000);
        t_mfc0(5'd15, 3'd0);
        chk("read_prid", rsp_rdata, 32'h0001_8000);

        // Write masks and read-back
        for (int i = 0; i < 14; i++) begin
            t_mtc0(tbl[i].a, tbl[i].s, tbl[i].wd);
            t_mfc0(tbl[i].a, tbl[i].s);
            chk($sformatf("tbl%0d_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("tbl%0d_rdata", i), rsp_rdata, tbl[i].exp);
        end

        // Timer match latency and clear
        t_reset(1);
        t_mtc0(5'd9, 3'd0, 32'd0);
        t_mtc0(5'd11, 3'd0, 32'd5);
        found = 1'b0;
        k_hit = 0;
        for (int k = 1; k <= 40 && !found; k++) begin
            t_none();
            if (cause[30]) begin found = 1'b1; k_hit = k; end
        end
        n_tests++;
        if (!(found && k_hit >= 10 && k_hit <= 11)) begin
            n_fail++;
            $display("FAIL ti_latency: got %0d cycles (seen=%0d) expected 10..11", k_hit, found);
        end
        t_mtc0(5'd11, 3'd0, 32'd100);
        chk("ti_cleared", 32'(cause[30]), 32'd0);

        // Interrupt gating through EXL
        t_reset(1);
        t_mtc0(5'd9, 3'd0, 32'd0);
        t_mtc0(5'd11, 3'd0, 32'd2);
        for (int k = 0; k < 20 && !cause[30]; k++) t_none();
        chk("ti_set_for_int", 32'(cause[30]), 32'd1);
        t_mtc0(5'd12, 3'd0, 32'h0000_8001);
        chk("int_req_on", 32'(int_req), 32'd1);
        t_exc(5'd0, 1'b0, 32'h40, 1'b0, 32'd0);
        chk("exl_set", 32'(status[1]), 32'd1);
        chk("int_req_masked", 32'(int_req), 32'd0);
        t_eret();
        chk("int_req_after_eret", 32'(int_req), 32'd1);

        // Nested exception keeps EPC
        t_reset(1);
        t_exc(5'd8, 1'b1, 32'h100, 1'b0, 32'd0);
        t_exc(5'd12, 1'b0, 32'h200, 1'b1, 32'hABCD_E123);
        chk("nested_epc", epc, 32'h100);
        chk("nested_code", 32'(cause[6:2]), 32'd12);
        chk("nested_bd", 32'(cause[31]), 32'd1);
        chk("badva_entryhi", entryhi, 32'hABCD_E000);
        t_mfc0(5'd8, 3'd0);
        chk("badva_read", rsp_rdata, 32'hABCD_E123);

        // Wired/Random sequence
        t_reset(1);
        t_mtc0(5'd6, 3'd0, 32'd3);
        chk("random_after_wired", 32'(random), 32'd15);
        for (int k = 1; k <= 12; k++) begin
            t_none();
            chk($sformatf("random_seq%0d", k), 32'(random), (k <= 11) ? 32'(15 - k) : 32'd15);
        end

        // Count write on a tick, and Count wrap
        t_reset(1);
        t_mtc0(5'd9, 3'd0, 32'd0);
        t_none();
        t_mtc0(5'd9, 3'd0, 32'h0000_ABCD);
        t_mfc0(5'd9, 3'd0);
        chk("count_write_vs_tick", rsp_rdata, 32'h0000_ABCD);
        t_mtc0(5'd9, 3'd0, 32'hFFFF_FFFF);
        t_none();
        t_none();
        t_mfc0(5'd9, 3'd0);
        chk("count_wrap", rsp_rdata, 32'd0);

        // Reset drops an outstanding read
        cyc(1, 3'd2, 5'd12, 3'd0, 0, 0, 0, 0, 0, 0);
        chk("rst_drops_rsp", 32'(rsp_valid), 32'd0);

        // Randomized traffic against the model
        t_reset(1);
        for (int i = 0; i < 700; i++) begin
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 7) == 0) ext_val = 6'($urandom);
            if (r < 2) begin
                t_reset(1);
            end else if (r < 30) begin
                t_none();
            end else if (r < 55) begin
                a  = pick_addr(int'($urandom_range(0, 12)));
                wd = $urandom;
                if (a == 5'd11) wd = mdl_count() + 32'($urandom_range(1, 6));
                if (a == 5'd9 && $urandom_range(0, 3) == 0) wd = 32'hFFFF_FFF8;
                t_mtc0(a, ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd0, wd);
            end else if (r < 80) begin
                t_mfc0(pick_addr(int'($urandom_range(0, 12))),
                       ($urandom_range(0, 7) == 0) ? 3'd2 : 3'd0);
            end else if (r < 90) begin
                t_exc(5'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom);
            end else begin
                t_eret();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
